// File: rtl/encoder_level_arbiter.sv
// Per-channel clamped level keeper for rotary encoders with a round-robin
// scheduler that emits one level update at a time over a valid/ready port.
`timescale 1ns/1ps
module encoder_level_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int LVL_W     = 6,
  parameter int MAX_LEVEL = 36,
  parameter int DEF_LEVEL = 18,
  parameter int ACC_W     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       step_cw,
  input  logic [NUM_CH-1:0]       step_ccw,
  input  logic                    preset_valid,
  output logic                    preset_ready,
  input  logic [2:0]              preset_ch,
  input  logic [LVL_W-1:0]        preset_level,
  output logic                    lvl_valid,
  input  logic                    lvl_ready,
  output logic [2:0]              lvl_ch,
  output logic [LVL_W-1:0]        lvl_data,
  output logic [NUM_CH*LVL_W-1:0] level_bus
);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SUM_W = LVL_W + ACC_W;
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'((1 << (ACC_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] ACC_MIN = -ACC_MAX;
  localparam logic signed [ACC_W-1:0] ONE     = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] NEG_ONE = -ONE;
  localparam logic signed [SUM_W-1:0] MAX_S   = SUM_W'(MAX_LEVEL);
  localparam logic [LVL_W-1:0]        MAX_L   = LVL_W'(MAX_LEVEL);
  localparam logic [LVL_W-1:0]        DEF_L   = LVL_W'(DEF_LEVEL);
  localparam logic [IDX_W-1:0]        LAST_CH = IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, APPLY = 2'd1, SEND = 2'd2} state_t;

  state_t                   state_q, state_d;
  logic [LVL_W-1:0]         level_q [NUM_CH];
  logic [LVL_W-1:0]         level_d [NUM_CH];
  logic signed [ACC_W-1:0]  acc_q   [NUM_CH];
  logic signed [ACC_W-1:0]  acc_d   [NUM_CH];
  logic [NUM_CH-1:0]        force_q, force_d;
  logic [IDX_W-1:0]         ptr_q, ptr_d;
  logic [IDX_W-1:0]         ch_q, ch_d;
  logic signed [ACC_W-1:0]  delta_q, delta_d;
  logic                     fflag_q, fflag_d;
  logic                     lvl_valid_q, lvl_valid_d;
  logic [2:0]               lvl_ch_q, lvl_ch_d;
  logic [LVL_W-1:0]         lvl_data_q, lvl_data_d;

  logic signed [ACC_W-1:0]  step_s  [NUM_CH];
  logic signed [ACC_W-1:0]  acc_sat [NUM_CH];
  logic [NUM_CH-1:0]        elig;
  logic                     grant_found;
  logic [IDX_W-1:0]         grant_ch;
  int                       scan_idx;
  logic signed [SUM_W-1:0]  sum_s;
  logic [LVL_W-1:0]         new_level;
  logic                     preset_in_range;
  logic [IDX_W-1:0]         pidx;
  logic [LVL_W-1:0]         preset_lvl_clamped;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign step_s[gi] = (step_cw[gi] && !step_ccw[gi]) ? ONE :
                          (step_ccw[gi] && !step_cw[gi]) ? NEG_ONE : '0;
      assign acc_sat[gi] = ((step_s[gi] == ONE && acc_q[gi] == ACC_MAX) ||
                            (step_s[gi] == NEG_ONE && acc_q[gi] == ACC_MIN))
                           ? acc_q[gi] : acc_q[gi] + step_s[gi];
      assign elig[gi] = (acc_q[gi] != '0) || force_q[gi];
      assign level_bus[gi*LVL_W +: LVL_W] = level_q[gi];
    end
  endgenerate

  // Round-robin: first eligible channel after the last served one.
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = '0;
    scan_idx    = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      scan_idx = int'(ptr_q) + k;
      if (scan_idx >= NUM_CH) scan_idx = scan_idx - NUM_CH;
      if (!grant_found && elig[IDX_W'(scan_idx)]) begin
        grant_found = 1'b1;
        grant_ch    = IDX_W'(scan_idx);
      end
    end
  end

  assign sum_s = $signed({{ACC_W{1'b0}}, level_q[ch_q]}) +
                 $signed({{LVL_W{delta_q[ACC_W-1]}}, delta_q});

  always_comb begin
    if (sum_s[SUM_W-1])      new_level = '0;
    else if (sum_s > MAX_S)  new_level = MAX_L;
    else                     new_level = sum_s[LVL_W-1:0];
  end

  assign preset_in_range    = ({1'b0, preset_ch} < 4'(NUM_CH));
  assign pidx               = preset_ch[IDX_W-1:0];
  assign preset_lvl_clamped = (preset_level > MAX_L) ? MAX_L : preset_level;

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    acc_d       = acc_sat;
    force_d     = force_q;
    ptr_d       = ptr_q;
    ch_d        = ch_q;
    delta_d     = delta_q;
    fflag_d     = fflag_q;
    lvl_valid_d = lvl_valid_q;
    lvl_ch_d    = lvl_ch_q;
    lvl_data_d  = lvl_data_q;
    case (state_q)
      IDLE: begin
        if (preset_valid) begin
          if (preset_in_range) begin
            level_d[pidx] = preset_lvl_clamped;
            acc_d[pidx]   = '0;
            force_d[pidx] = 1'b1;
          end
        end else if (grant_found) begin
          ch_d              = grant_ch;
          delta_d           = acc_q[grant_ch];
          fflag_d           = force_q[grant_ch];
          force_d[grant_ch] = 1'b0;
          // Keep this cycle's step so nothing is lost across the grant.
          acc_d[grant_ch]   = step_s[grant_ch];
          state_d           = APPLY;
        end
      end
      APPLY: begin
        level_d[ch_q] = new_level;
        if (new_level != level_q[ch_q] || fflag_q) begin
          lvl_ch_d    = 3'(ch_q);
          lvl_data_d  = new_level;
          lvl_valid_d = 1'b1;
          state_d     = SEND;
        end else begin
          ptr_d   = ch_q;
          state_d = IDLE;
        end
      end
      SEND: begin
        if (lvl_ready) begin
          lvl_valid_d = 1'b0;
          ptr_d       = ch_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      for (int i = 0; i < NUM_CH; i++) begin
        level_q[i] <= DEF_L;
        acc_q[i]   <= '0;
      end
      force_q     <= '0;
      ptr_q       <= LAST_CH;
      ch_q        <= '0;
      delta_q     <= '0;
      fflag_q     <= 1'b0;
      lvl_valid_q <= 1'b0;
      lvl_ch_q    <= '0;
      lvl_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      acc_q       <= acc_d;
      force_q     <= force_d;
      ptr_q       <= ptr_d;
      ch_q        <= ch_d;
      delta_q     <= delta_d;
      fflag_q     <= fflag_d;
      lvl_valid_q <= lvl_valid_d;
      lvl_ch_q    <= lvl_ch_d;
      lvl_data_q  <= lvl_data_d;
    end
  end

  assign preset_ready = (state_q == IDLE);
  assign lvl_valid    = lvl_valid_q;
  assign lvl_ch       = lvl_ch_q;
  assign lvl_data     = lvl_data_q;

endmodule
